// File: rtl/stream_packet_arbiter.sv
// Round-robin arbiter merging NP framed valid/ready streams into one registered
// output stream; a grant is held for a whole packet so packets never interleave.
module stream_packet_arbiter #(
    parameter int DW = 8,
    parameter int NP = 3,
    parameter int IW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NP*DW-1:0] stream_s_data_i,
    input  logic [NP-1:0]    stream_s_valid_i,
    input  logic [NP-1:0]    stream_s_last_i,
    output logic [NP-1:0]    stream_s_ready_o,
    output logic [DW-1:0]    stream_m_data_o,
    output logic             stream_m_valid_o,
    output logic             stream_m_last_o,
    output logic [IW-1:0]    stream_m_id_o,
    input  logic             stream_m_ready_i
);

    localparam int PW = (NP > 1) ? $clog2(NP) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] ptr_nxt_s;
    logic [PW-1:0] lock_r;
    logic [PW-1:0] lock_nxt_s;
    logic [PW-1:0] gnt_s;
    logic [PW-1:0] cand_s;
    logic          gnt_vld_s;
    logic          pipe_ready_s;
    logic          accept_s;
    logic          gnt_last_s;
    logic [DW-1:0] gnt_data_s;

    logic [DW-1:0] data_r;
    logic          valid_r;
    logic          last_r;
    logic [IW-1:0] id_r;

    assign pipe_ready_s = ~valid_r | stream_m_ready_i;

    // Grant selection: locked port while busy, else first valid port after ptr.
    // The search runs from the farthest candidate down so the nearest one wins.
    always_comb begin
        gnt_s     = '0;
        gnt_vld_s = 1'b0;
        cand_s    = '0;
        if (state_r == ST_BUSY) begin
            gnt_s     = lock_r;
            gnt_vld_s = 1'b1;
        end else begin
            for (int i = NP; i >= 1; i--) begin
                cand_s    = PW'((int'(ptr_r) + i) % NP);
                gnt_s     = stream_s_valid_i[cand_s] ? cand_s : gnt_s;
                gnt_vld_s = gnt_vld_s | stream_s_valid_i[cand_s];
            end
        end
    end

    // Ready goes only to the granted port, and never while reset is held.
    always_comb begin
        stream_s_ready_o = '0;
        if (gnt_vld_s && rst_n) begin
            stream_s_ready_o[gnt_s] = pipe_ready_s;
        end else begin
            stream_s_ready_o = '0;
        end
    end

    assign gnt_data_s = stream_s_data_i[int'(gnt_s)*DW +: DW];
    assign gnt_last_s = stream_s_last_i[gnt_s];
    assign accept_s   = gnt_vld_s & stream_s_valid_i[gnt_s] & stream_s_ready_o[gnt_s];

    // Packet framing state machine: next state, lock and round-robin pointer.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        lock_nxt_s  = lock_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && gnt_last_s) begin
                    ptr_nxt_s = gnt_s;
                end else if (accept_s) begin
                    state_nxt_s = ST_BUSY;
                    lock_nxt_s  = gnt_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (accept_s && gnt_last_s) begin
                    state_nxt_s = ST_IDLE;
                    ptr_nxt_s   = lock_r;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; ptr resets to NP-1 so port 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= PW'(NP - 1);
            lock_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            lock_r  <= lock_nxt_s;
        end
    end

    // Output pipe stage: load on accept, drop valid once downstream consumes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            id_r    <= '0;
        end else if (accept_s) begin
            data_r  <= gnt_data_s;
            valid_r <= 1'b1;
            last_r  <= gnt_last_s;
            id_r    <= IW'(gnt_s);
        end else if (stream_m_ready_i) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign stream_m_data_o  = data_r;
    assign stream_m_valid_o = valid_r;
    assign stream_m_last_o  = last_r;
    assign stream_m_id_o    = id_r;

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Randomized bench for stream_packet_arbiter: a transaction-level arbitration
// model pushes expected beats into a queue that a separate output monitor drains.
module tb_stream_packet_arbiter;

    localparam int DW = 8;
    localparam int NP = 3;
    localparam int IW = 2;

    logic             clk;
    logic             rst_n;
    logic [NP*DW-1:0] s_data;
    logic [NP-1:0]    s_valid;
    logic [NP-1:0]    s_last;
    logic [NP-1:0]    s_ready;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic             m_last;
    logic [IW-1:0]    m_id;
    logic             m_ready;

    stream_packet_arbiter #(.DW(DW), .NP(NP), .IW(IW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stream_s_data_i  (s_data),
        .stream_s_valid_i (s_valid),
        .stream_s_last_i  (s_last),
        .stream_s_ready_o (s_ready),
        .stream_m_data_o  (m_data),
        .stream_m_valid_o (m_valid),
        .stream_m_last_o  (m_last),
        .stream_m_id_o    (m_id),
        .stream_m_ready_i (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Source state: each port walks its own sequence of beats.
    int seq[NP];
    bit cur_last[NP];

    // Reference model: packet lock, last-served port, output-slot occupancy.
    bit busy;
    int lock;
    int last_served;
    bit out_full;
    bit was_rst;

    // Decision captured before the edge, applied to the model at the edge.
    bit acc_c;
    int g_c;
    bit last_c;
    bit rst_c;
    bit rdy_c;

    // Phase knobs.
    logic [NP-1:0] mask;
    int pv;
    int pr;
    int prst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit do_rst;
        int g;
        logic [NP-1:0] exp_rdy;
        @(posedge clk);
        was_rst = !rst_c;
        if (!rst_c) begin
            busy = 1'b0;
            lock = 0;
            last_served = NP - 1;
            out_full = 1'b0;
            exp_q.delete();
        end else begin
            if (acc_c) begin
                seq[g_c]++;
                cur_last[g_c] = ($urandom_range(0, 2) == 0);
                if (last_c) begin
                    last_served = g_c;
                    busy = 1'b0;
                end else begin
                    busy = 1'b1;
                    lock = g_c;
                end
                out_full = 1'b1;
            end else if (rdy_c) begin
                out_full = 1'b0;
            end
        end
        #1;
        do_rst  = ($urandom % 100) < prst;
        rst_n   = !do_rst;
        m_ready = ($urandom % 100) < pr;
        for (int k = 0; k < NP; k++) begin
            s_valid[k] = mask[k] && (($urandom % 100) < pv);
            s_data[k*DW +: DW] = DW'(k * 64 + seq[k] % 64);
            s_last[k] = cur_last[k];
        end
        @(negedge clk);
        if (was_rst) begin
            check("rst_valid", m_valid, 0);
            check("rst_id", m_id, 0);
            check("rst_data", m_data, 0);
            check("rst_last", m_last, 0);
        end
        check("out_valid", m_valid, out_full);
        g = -1;
        if (busy) begin
            g = lock;
        end else begin
            for (int i = 1; i <= NP; i++) begin
                if (g < 0 && s_valid[(last_served + i) % NP]) g = (last_served + i) % NP;
            end
        end
        exp_rdy = '0;
        if (g >= 0 && rst_n && (!out_full || m_ready)) exp_rdy[g] = 1'b1;
        check("s_ready", s_ready, exp_rdy);
        acc_c = (g >= 0) && s_valid[g] && exp_rdy[g];
        if (acc_c) exp_q.push_back('{id: IW'(g), data: s_data[g*DW +: DW], last: s_last[g]});
        g_c    = g;
        last_c = (g >= 0) ? s_last[g] : 1'b0;
        rst_c  = rst_n;
        rdy_c  = m_ready;
    endtask

    task automatic phase(input logic [NP-1:0] msk, input int v, input int r, input int rs, input int n);
        mask = msk;
        pv   = v;
        pr   = r;
        prst = rs;
        for (int c = 0; c < n; c++) cycle();
    endtask

    // Output monitor: pop on every handshake, check hold-stability under stall.
    initial begin : monitor
        beat_t got;
        beat_t prev;
        beat_t want;
        bit stalled;
        stalled = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            got = '{id: m_id, data: m_data, last: m_last};
            if (rst_n && m_valid) begin
                if (stalled) begin
                    check("stall_hold", got, prev);
                end
                if (m_ready) begin
                    check("queue_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        want = exp_q.pop_front();
                        check("beat_id", got.id, want.id);
                        check("beat_data", got.data, want.data);
                        check("beat_last", got.last, want.last);
                    end
                end
                stalled = !m_ready;
                prev    = got;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin : stim
        rst_n   = 1'b0;
        m_ready = 1'b0;
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
        for (int k = 0; k < NP; k++) begin
            seq[k] = 0;
            cur_last[k] = ($urandom_range(0, 2) == 0);
        end
        busy = 1'b0; lock = 0; last_served = NP - 1; out_full = 1'b0;
        acc_c = 1'b0; g_c = -1; last_c = 1'b0; rst_c = 1'b0; rdy_c = 1'b0; was_rst = 1'b0;

        phase(3'b000, 0, 100, 100, 2);   // reset
        phase(3'b010, 100, 100, 0, 12);  // single port streaming
        phase(3'b111, 100, 100, 0, 24);  // all ports contending
        phase(3'b101, 100, 30, 0, 40);   // heavy backpressure
        phase(3'b111, 40, 100, 0, 60);   // sparse valids, lock stalls
        phase(3'b111, 70, 70, 0, 300);   // mixed random
        phase(3'b100, 100, 100, 0, 3);   // port 2 mid-packet
        phase(3'b100, 100, 100, 100, 1); // reset during it
        phase(3'b101, 100, 100, 0, 10);  // ports 0 and 2 after release
        phase(3'b111, 80, 60, 3, 400);   // random with sporadic resets
        phase(3'b000, 0, 100, 0, 6);     // drain
        check("drain_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
